// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier that borrows a shared combinational ALU for its adds.
// Optional MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module alu_mul_sequencer #(
    parameter logic [3:0]  ADD_OP     = 4'b0000,
    parameter int unsigned ITERATIONS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start_i,
    input  logic [31:0] Multiplicand_i,
    input  logic [31:0] Multiplier_i,
    input  logic [3:0]  Host_ALU_Operation_i,
    input  logic [31:0] Host_A_i,
    input  logic [31:0] Host_B_i,
    input  logic [31:0] ALU_Result_i,
    output logic [3:0]  ALU_Operation_o,
    output logic [31:0] ALU_A_o,
    output logic [31:0] ALU_B_o,
    output logic        Busy_o,
    output logic        Done_o,
    output logic [31:0] Product_o
);

    localparam int unsigned CntW = $clog2(ITERATIONS + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(ITERATIONS - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            r_state;
    logic [31:0]       r_acc;
    logic [31:0]       r_m;
    logic [31:0]       r_q;
    logic [CntW-1:0]   r_cnt;
    logic              r_busy;
    logic              r_done;
    logic [31:0]       r_product;

    logic              w_in_calc;
    logic [31:0]       w_acc_next;

    assign w_in_calc  = (r_state == StCalc);
    assign w_acc_next = r_q[0] ? ALU_Result_i : r_acc;

    // The shared ALU belongs to the host except while a multiply is running.
    assign ALU_Operation_o = w_in_calc ? ADD_OP : Host_ALU_Operation_i;
    assign ALU_A_o         = w_in_calc ? r_acc  : Host_A_i;
    assign ALU_B_o         = w_in_calc ? r_m    : Host_B_i;

    assign Busy_o    = r_busy;
    assign Done_o    = r_done;
    assign Product_o = r_product;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_acc     <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    r_done <= 1'b0;
                    if (Start_i) begin
                        r_acc   <= '0;
                        r_m     <= Multiplicand_i;
                        r_q     <= Multiplier_i;
                        r_cnt   <= '0;
                        r_state <= StCalc;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                end
                StCalc: begin
`ifdef MUL_EARLY_EXIT_EN
                    // q reaches zero within 32 shifts, so this alone bounds the run.
                    if (r_q == '0) begin
                        r_state   <= StDone;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_product <= r_acc;
                    end else begin
                        r_acc <= w_acc_next;
                        r_m   <= r_m << 1;
                        r_q   <= r_q >> 1;
                        r_cnt <= r_cnt + 1'b1;
                    end
`else
                    r_acc <= w_acc_next;
                    r_m   <= r_m << 1;
                    r_q   <= r_q >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CntLast) begin
                        r_state   <= StDone;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_product <= w_acc_next;
                    end
`endif
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer (default build): product table plus
// hand sequences for host pass-through, ignored restart, back-to-back and reset abort.
module tb_alu_mul_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start_i;
    logic [31:0] Multiplicand_i;
    logic [31:0] Multiplier_i;
    logic [3:0]  Host_ALU_Operation_i;
    logic [31:0] Host_A_i;
    logic [31:0] Host_B_i;
    logic [31:0] ALU_Result_i;
    logic [3:0]  ALU_Operation_o;
    logic [31:0] ALU_A_o;
    logic [31:0] ALU_B_o;
    logic        Busy_o;
    logic        Done_o;
    logic [31:0] Product_o;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Shared ALU model: op 0 add, op 1 subtract, otherwise xor.
    always_comb begin
        case (ALU_Operation_o)
            4'b0000: ALU_Result_i = ALU_A_o + ALU_B_o;
            4'b0001: ALU_Result_i = ALU_A_o - ALU_B_o;
            default: ALU_Result_i = ALU_A_o ^ ALU_B_o;
        endcase
    end

    alu_mul_sequencer dut (
        .clk                  (clk),
        .reset                (reset),
        .Start_i              (Start_i),
        .Multiplicand_i       (Multiplicand_i),
        .Multiplier_i         (Multiplier_i),
        .Host_ALU_Operation_i (Host_ALU_Operation_i),
        .Host_A_i             (Host_A_i),
        .Host_B_i             (Host_B_i),
        .ALU_Result_i         (ALU_Result_i),
        .ALU_Operation_o      (ALU_Operation_o),
        .ALU_A_o              (ALU_A_o),
        .ALU_B_o              (ALU_B_o),
        .Busy_o               (Busy_o),
        .Done_o               (Done_o),
        .Product_o            (Product_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Start a multiply in the current cycle; returns edges from accept to Done_o
    // (-1 if none within 40) and number of sampled cycles with Busy_o high.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        Start_i = 1'b1;
        Multiplicand_i = a;
        Multiplier_i = b;
        @(posedge clk);
        #1;
        Start_i = 1'b0;
        lat = -1;
        busy_cnt = Busy_o ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (Done_o) begin
                lat = k;
                break;
            end
            if (Busy_o) busy_cnt++;
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] prod;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat;
        int busy;
        int seen_done;

        vecs[0] = '{32'd3,         32'd5,         32'd15};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[2] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
        vecs[3] = '{32'd7,         32'd9,         32'd63};
        vecs[4] = '{32'd12345,     32'd6789,      32'd83810205};
        vecs[5] = '{32'd0,         32'd123,       32'd0};
        vecs[6] = '{32'h8000_0000, 32'd3,         32'h8000_0000};
        vecs[7] = '{32'h0001_0001, 32'h0000_FFFF, 32'hFFFF_FFFF};

        reset = 1'b1;
        Start_i = 1'b1;
        Multiplicand_i = 32'd9;
        Multiplier_i = 32'd9;
        Host_ALU_Operation_i = 4'b0001;
        Host_A_i = 32'd10;
        Host_B_i = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        // Reset overrides a concurrent Start_i.
        check("reset_busy", {31'd0, Busy_o}, 32'd0);
        check("reset_done", {31'd0, Done_o}, 32'd0);
        check("reset_product", Product_o, 32'd0);
        reset = 1'b0;
        Start_i = 1'b0;
        @(posedge clk);
        #1;
        check("idle_busy", {31'd0, Busy_o}, 32'd0);
        check("host_op", {28'd0, ALU_Operation_o}, 32'd1);
        check("host_a", ALU_A_o, 32'd10);
        check("host_b", ALU_B_o, 32'd3);

        // Table, issued back-to-back so every entry after the first goes DONE -> CALC.
        for (int i = 0; i < 8; i++) begin
            do_mul(vecs[i].a, vecs[i].b, lat, busy);
            check($sformatf("v%0d_latency", i), lat, 32'd32);
            check($sformatf("v%0d_busy_cycles", i), busy, 32'd32);
            check($sformatf("v%0d_product", i), Product_o, vecs[i].prod);
        end
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, Done_o}, 32'd0);
        check("product_held", Product_o, 32'hFFFF_FFFF);

        // During CALC the ALU shows ADD_OP with acc/m; A=3, B=5.
        @(negedge clk);
        Start_i = 1'b1;
        Multiplicand_i = 32'd3;
        Multiplier_i = 32'd5;
        @(posedge clk);
        #1;
        Start_i = 1'b0;
        check("calc_op", {28'd0, ALU_Operation_o}, 32'd0);
        check("calc_a0", ALU_A_o, 32'd0);
        check("calc_b0", ALU_B_o, 32'd3);
        @(posedge clk);
        #1;
        check("calc_a1", ALU_A_o, 32'd3);
        check("calc_b1", ALU_B_o, 32'd6);
        @(posedge clk);
        #1;
        check("calc_a2", ALU_A_o, 32'd3);
        check("calc_b2", ALU_B_o, 32'd12);
        seen_done = 0;
        for (int k = 3; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (Done_o) begin
                seen_done = k;
                break;
            end
        end
        check("calc_latency", seen_done, 32'd32);
        check("calc_product", Product_o, 32'd15);
        @(posedge clk);
        #1;

        // Second Start at edge N+5 is ignored.
        @(negedge clk);
        Start_i = 1'b1;
        Multiplicand_i = 32'd7;
        Multiplier_i = 32'd9;
        @(posedge clk);
        #1;
        Start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        Start_i = 1'b1;
        Multiplicand_i = 32'd1;
        Multiplier_i = 32'd1;
        @(posedge clk);
        #1;
        Start_i = 1'b0;
        seen_done = -1;
        for (int k = 6; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (Done_o) begin
                seen_done = k;
                break;
            end
        end
        check("restart_latency", seen_done, 32'd32);
        check("restart_product", Product_o, 32'd63);
        @(posedge clk);
        #1;

        // Reset at edge N+10 aborts without a Done_o pulse.
        @(negedge clk);
        Start_i = 1'b1;
        Multiplicand_i = 32'd5;
        Multiplier_i = 32'd6;
        @(posedge clk);
        #1;
        Start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("pre_abort_busy", {31'd0, Busy_o}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", {31'd0, Busy_o}, 32'd0);
        check("abort_done", {31'd0, Done_o}, 32'd0);
        check("abort_product", Product_o, 32'd0);
        check("abort_host_a", ALU_A_o, 32'd10);
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (Done_o || Busy_o) seen_done = 1;
        end
        check("abort_quiet", seen_done, 32'd0);
        do_mul(32'd2, 32'd4, lat, busy);
        check("after_abort_latency", lat, 32'd32);
        check("after_abort_product", Product_o, 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
